// File: rtl/mnist_pkg.sv
// Shared types and constants for the MNIST layer sequencer and its argmax tracker.
package mnist_pkg;

    localparam int N_IN      = 784;
    localparam int N_HID     = 10;
    localparam int N_OUT     = 10;
    localparam int MAC_LAT   = 2;
    localparam int ACC_W     = 32;
    localparam int ADDR_W    = 13;
    localparam int XADDR_W   = 10;
    localparam int IDX_W     = 4;
    localparam int L2_W_BASE = N_HID * N_IN;

    localparam int LAT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    localparam logic [XADDR_W-1:0] L1_LAST_I = XADDR_W'(N_IN - 1);
    localparam logic [XADDR_W-1:0] L2_LAST_I = XADDR_W'(N_HID - 1);
    localparam logic [IDX_W-1:0]   L1_LAST_N = IDX_W'(N_HID - 1);
    localparam logic [IDX_W-1:0]   L2_LAST_N = IDX_W'(N_OUT - 1);
    localparam logic [LAT_W-1:0]   LAT_LAST  = LAT_W'(MAC_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_L1_MAC,
        S_L1_DRAIN,
        S_L1_WB,
        S_L2_MAC,
        S_L2_DRAIN,
        S_L2_WB,
        S_DONE
    } seq_state_e;

    function automatic logic is_layer2(input seq_state_e s);
        return (s == S_L2_MAC) || (s == S_L2_DRAIN) || (s == S_L2_WB);
    endfunction

endpackage

// File: rtl/mnist_layer_sequencer_argmax.sv
// Signed running-maximum tracker: strict-greater compare keeps the lowest index on ties.
module mnist_argmax_track
    import mnist_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en_i,
    input  logic                    first_i,
    input  logic signed [ACC_W-1:0] val_i,
    input  logic [IDX_W-1:0]        idx_i,
    output logic [IDX_W-1:0]        best_idx_o
);

    logic signed [ACC_W-1:0] best_q, best_d;
    logic [IDX_W-1:0]        idx_q, idx_d;

    // The first candidate always loads, so a stale best from a previous image never wins.
    always_comb begin
        best_d = best_q;
        idx_d  = idx_q;
        if (en_i && (first_i || (val_i > best_q))) begin
            best_d = val_i;
            idx_d  = idx_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_q <= '0;
            idx_q  <= '0;
        end else begin
            best_q <= best_d;
            idx_q  <= idx_d;
        end
    end

    assign best_idx_o = idx_q;

endmodule

// File: rtl/mnist_layer_sequencer.sv
// Two-layer MNIST MAC sequencer with incremental argmax over the output layer.
// Optional cycle counter port perf_cycles_o is enabled by defining MNIST_SEQ_PERF_EN.
module mnist_layer_sequencer
    import mnist_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [IDX_W-1:0]        class_idx_o,
    output logic [ADDR_W-1:0]       w_addr_o,
    output logic [XADDR_W-1:0]      x_addr_o,
    output logic                    x_sel_o,
    output logic                    mac_clr_o,
    output logic                    mac_en_o,
    input  logic signed [ACC_W-1:0] acc_in_i,
    output logic                    act_we_o,
    output logic [IDX_W-1:0]        act_addr_o
`ifdef MNIST_SEQ_PERF_EN
    ,
    output logic [31:0]             perf_cycles_o
`endif
);

    seq_state_e          state_q, state_d;
    logic [XADDR_W-1:0]  i_q, i_d;
    logic [IDX_W-1:0]    n_q, n_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [ADDR_W-1:0]   w_q, w_d;
    logic                mac_en_q, mac_clr_q;
    logic [IDX_W-1:0]    class_q, class_d;
    logic                issue;
    logic                argmax_en;
    logic [IDX_W-1:0]    best_idx;

    assign issue     = (state_q == S_L1_MAC) || (state_q == S_L2_MAC);
    assign argmax_en = (state_q == S_L2_WB);

    // Weight rows of both layers are stored back to back, so one running
    // counter walks n*N_IN+i and then L2_W_BASE+n*N_HID+i without a multiplier.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        n_d     = n_q;
        lat_d   = lat_q;
        w_d     = w_q;
        class_d = class_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_L1_MAC;
                    i_d     = '0;
                    n_d     = '0;
                    lat_d   = '0;
                    w_d     = '0;
                end
            end
            S_L1_MAC: begin
                w_d = w_q + 1'b1;
                if (i_q == L1_LAST_I) begin
                    i_d     = '0;
                    lat_d   = '0;
                    state_d = S_L1_DRAIN;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            S_L1_DRAIN: begin
                if (lat_q == LAT_LAST) begin
                    state_d = S_L1_WB;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            S_L1_WB: begin
                if (n_q == L1_LAST_N) begin
                    n_d     = '0;
                    state_d = S_L2_MAC;
                end else begin
                    n_d     = n_q + 1'b1;
                    state_d = S_L1_MAC;
                end
            end
            S_L2_MAC: begin
                w_d = w_q + 1'b1;
                if (i_q == L2_LAST_I) begin
                    i_d     = '0;
                    lat_d   = '0;
                    state_d = S_L2_DRAIN;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            S_L2_DRAIN: begin
                if (lat_q == LAT_LAST) begin
                    state_d = S_L2_WB;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            S_L2_WB: begin
                if (n_q == L2_LAST_N) begin
                    n_d     = '0;
                    state_d = S_DONE;
                end else begin
                    n_d     = n_q + 1'b1;
                    state_d = S_L2_MAC;
                end
            end
            S_DONE: begin
                class_d = best_idx;
                w_d     = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            i_q       <= '0;
            n_q       <= '0;
            lat_q     <= '0;
            w_q       <= '0;
            class_q   <= '0;
            mac_en_q  <= 1'b0;
            mac_clr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            n_q       <= n_d;
            lat_q     <= lat_d;
            w_q       <= w_d;
            class_q   <= class_d;
            mac_en_q  <= issue;
            mac_clr_q <= issue && (i_q == '0);
        end
    end

    mnist_argmax_track u_argmax (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (argmax_en),
        .first_i    (n_q == '0),
        .val_i      (acc_in_i),
        .idx_i      (n_q),
        .best_idx_o (best_idx)
    );

    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);
    assign act_we_o    = (state_q == S_L1_WB);
    assign act_addr_o  = act_we_o ? n_q : '0;
    assign x_sel_o     = is_layer2(state_q);
    assign x_addr_o    = i_q;
    assign w_addr_o    = w_q;
    assign mac_en_o    = mac_en_q;
    assign mac_clr_o   = mac_clr_q;
    assign class_idx_o = class_q;

`ifdef MNIST_SEQ_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if ((state_q == S_IDLE) && start_i) begin
            perf_d = '0;
        end else if (busy_o && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles_o = perf_q;
`endif

endmodule

// File: tb/tb_mnist_layer_sequencer.sv
// Self-checking bench for mnist_layer_sequencer: table-driven argmax cases, random runs, reset abort.
module tb_mnist_layer_sequencer;

    localparam int M_IN    = 784;
    localparam int M_HID   = 10;
    localparam int M_LAT   = 2;
    localparam int L1_SPAN = M_HID * (M_IN + M_LAT + 1);
    localparam int T_DONE  = 8001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        busy_o, done_o, x_sel_o, mac_clr_o, mac_en_o, act_we_o;
    logic [3:0]  class_idx_o, act_addr_o;
    logic [12:0] w_addr_o;
    logic [9:0]  x_addr_o;
    logic signed [31:0] acc_in_i = '0;
`ifdef MNIST_SEQ_PERF_EN
    logic [31:0] perf_cycles_o;
`endif

    int checks = 0;
    int errors = 0;
    logic [3:0] cls_model = 4'd0;

    always #5 clk = ~clk;

    mnist_layer_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .class_idx_o (class_idx_o),
        .w_addr_o    (w_addr_o),
        .x_addr_o    (x_addr_o),
        .x_sel_o     (x_sel_o),
        .mac_clr_o   (mac_clr_o),
        .mac_en_o    (mac_en_o),
        .acc_in_i    (acc_in_i),
        .act_we_o    (act_we_o),
        .act_addr_o  (act_addr_o)
`ifdef MNIST_SEQ_PERF_EN
        ,
        .perf_cycles_o (perf_cycles_o)
`endif
    );

    typedef struct packed {
        logic [9:0][31:0] v;
        logic [3:0]       cls;
    } vec_t;

    int raw [4][11] = '{
        '{5, -3, 9, 9, 2, 0, -1, 8, 1, 4, 2},
        '{-7, -2, -9, -5, -3, -8, -4, -6, -10, -11, 1},
        '{3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 0},
        '{-100, -1, 2147483646, -2147483647 - 1, 7, 2147483646, 6, 7, -3, 2147483647, 9}
    };
    vec_t tbl [4];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got=%0h required=%0h", nm, got, req);
        end
    endtask

    function automatic logic [36:0] outs();
        return {busy_o, done_o, mac_en_o, mac_clr_o, act_we_o, act_addr_o,
                x_sel_o, w_addr_o, x_addr_o, class_idx_o};
    endfunction

    // Cycle t counts from the accepting edge: t=1 is the first busy cycle.
    // kind: 0 none, 1 MAC (address issue), 2 drain, 3 write-back.
    function automatic void sched(input int t, output int kind, output int n,
                                  output int r, output bit l2);
        int len, u, span;
        kind = 0; n = 0; r = 0; l2 = 1'b0; len = 0; u = -1;
        if (t >= 1 && t <= L1_SPAN) begin
            u = t - 1; len = M_IN;
        end else if (t > L1_SPAN && t < T_DONE) begin
            u = t - 1 - L1_SPAN; len = M_HID; l2 = 1'b1;
        end
        if (u >= 0) begin
            span = len + M_LAT + 1;
            n = u / span;
            r = u % span;
            kind = (r < len) ? 1 : ((r < len + M_LAT) ? 2 : 3);
        end
    endfunction

    function automatic logic [3:0] argmax_ref(input logic [9:0][31:0] v);
        int b = 0;
        for (int k = 1; k < 10; k++)
            if ($signed(v[k]) > $signed(v[b])) b = k;
        return 4'(b);
    endfunction

    task automatic run_inf(input logic [9:0][31:0] v, input logic [3:0] exp_cls, input bit hold);
        int kind, n, r, pk, pn, pr, w, bad, bad_t, n_mac, n_we;
        bit l2, pl2;
        logic [36:0] got, req, mask, bad_got, bad_req;
        bad = 0; bad_t = -1; n_mac = 0; n_we = 0; bad_got = '0; bad_req = '0;
        start_i = 1'b1;
        @(posedge clk);
        for (int t = 1; t <= T_DONE; t++) begin
            @(negedge clk);
            start_i = hold || (t == 100) || (t == 5000);
            sched(t, kind, n, r, l2);
            sched(t - 1, pk, pn, pr, pl2);
            acc_in_i = (kind == 3 && l2) ? v[n] : $urandom;
            w = l2 ? (M_HID * M_IN + n * M_HID + r) : (n * M_IN + r);
            req  = {1'b1, (t == T_DONE), (pk == 1), (pk == 1 && pr == 0), (kind == 3 && !l2),
                    4'(n), l2, 13'(w), 10'(r), cls_model};
            mask = {5'b11111, {4{kind == 3 && !l2}}, (kind != 0),
                    {23{kind == 1}}, 4'hF};
            got = outs();
            if ((got & mask) !== (req & mask)) begin
                bad++;
                if (bad_t < 0) begin
                    bad_t = t; bad_got = got & mask; bad_req = req & mask;
                end
            end
            n_mac += int'(mac_en_o);
            n_we  += int'(act_we_o);
`ifdef MNIST_SEQ_PERF_EN
            if (t == 1) chk("perf_clear_on_start", 64'(perf_cycles_o), 64'd0);
`endif
        end
        @(negedge clk);
        start_i = hold;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL trace: %0d bad cycles, first t=%0d got=%h required=%h",
                     bad, bad_t, bad_got, bad_req);
        end
        chk("mac_en_total", 64'(n_mac), 64'd7940);
        chk("act_we_total", 64'(n_we), 64'd10);
        chk("class_idx", 64'(class_idx_o), 64'(exp_cls));
        chk("idle_after_done", {62'd0, busy_o, done_o}, 64'd0);
`ifdef MNIST_SEQ_PERF_EN
        chk("perf_after_done", 64'(perf_cycles_o), 64'd8001);
`endif
        cls_model = exp_cls;
    endtask

    task automatic idle_check(input int cycles);
        int seen = 0;
        start_i = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (busy_o || done_o) seen++;
`ifdef MNIST_SEQ_PERF_EN
            if (perf_cycles_o != 32'd8001 && perf_cycles_o != 32'd0) seen++;
`endif
        end
        chk("idle_stable", 64'(seen), 64'd0);
    endtask

    function automatic logic [9:0][31:0] rand_vec();
        logic [9:0][31:0] v;
        int tmp;
        for (int k = 0; k < 10; k++) begin
            tmp = int'($urandom_range(0, 40)) - 20;
            if ($urandom_range(0, 3) == 0) tmp = int'($urandom);
            v[k] = tmp;
        end
        return v;
    endfunction

    initial begin
        #(1_000_000 * 10);
        $display("FAIL watchdog: got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0][31:0] rv;
        int dseen;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 10; k++) tbl[i].v[k] = raw[i][k];
            tbl[i].cls = raw[i][10][3:0];
        end

        start_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'(outs()), 64'd0);
`ifdef MNIST_SEQ_PERF_EN
        chk("reset_perf", 64'(perf_cycles_o), 64'd0);
`endif
        start_i = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", 64'(outs()), 64'd0);

        for (int i = 0; i < 4; i++) begin
            run_inf(tbl[i].v, tbl[i].cls, 1'b0);
            idle_check(3);
        end

        // start held high: back-to-back inferences, nothing accepted while busy
        rv = rand_vec();
        run_inf(rv, argmax_ref(rv), 1'b1);
        rv = rand_vec();
        run_inf(rv, argmax_ref(rv), 1'b1);
        idle_check(3);

        // reset in the middle of layer 1
        start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        repeat (3999) @(posedge clk);
        #2;
        chk("abort_busy_before", 64'(busy_o), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_async_zero", 64'(outs()), 64'd0);
        dseen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_o || busy_o) dseen++;
        end
        rst_n = 1'b1;
        cls_model = 4'd0;
        repeat (5) begin
            @(negedge clk);
            if (done_o || busy_o) dseen++;
        end
        chk("abort_no_done", 64'(dseen), 64'd0);
        rv = rand_vec();
        run_inf(rv, argmax_ref(rv), 1'b0);
        idle_check(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
